jtag_tap_sync: RTL
==================

Name: jtag_tap_sync

Overview:
- Parametrised IEEE 1149.1 TAP controller; JTAG pins are oversampled into the single system clock domain, so no TCK clock tree is needed.
- Supports a configurable IR width and IDCODE value.
- Provides N user data registers of configurable width with parallel capture/update ports.
- Sits inside the tt_um top between the ui_in/uio pins and the chip-side user logic, replacing the fixed-width TAP.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE, 32'h1000_0CE3, value captured by IDCODE DR (bit0 must be 1)
NUM_USER_DR, 2, number of user data registers (1..8, must satisfy NUM_USER_DR+2 < 2**IR_WIDTH-1)
USER_DR_WIDTH, 8, width of each user DR (1..32)
SYNC_STAGES, 2, synchroniser depth for tck/tms/tdi (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tck  in  1  JTAG test clock (asynchronous pin)
tms  in  1  JTAG mode select
tdi  in  1  JTAG data in
tdo  out  1  JTAG data out
tdo_oe  out  1  high while shifting (Shift-DR/Shift-IR window)
tap_state  out  4  current TAP state encoding
ir_out  out  IR_WIDTH  current latched instruction
user_dr_in  in  NUM_USER_DR*USER_DR_WIDTH  parallel values captured in Capture-DR, DR k at slice k
user_dr_out  out  NUM_USER_DR*USER_DR_WIDTH  latched update values, DR k at slice k
user_update  out  NUM_USER_DR  one-clk pulse on Update-DR of selected user DR

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a clk edge) forces the following on that edge:
  - tap_state=TLR (4'hF), ir_out=1 (IDCODE), tdo=0, tdo_oe=0, user_dr_out=0, user_update=0.
  - All shift registers and synchroniser stages =0.
- tck, tms and tdi each pass through a SYNC_STAGES flop chain.
- tck edges are detected from the last two synchronised tck samples:
  - rise = synced tck is 1 and its previous sample was 0.
  - fall = synced tck is 0 and its previous sample was 1.
  - Latency from a tck pin edge to the action is SYNC_STAGES+1 clk.
- Timing requirement: tck high and low times each >=3 clk periods. Behaviour is undefined otherwise.
- State encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5.
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
  - Transitions follow standard 1149.1 using synced tms sampled at rise.
- Actions on rise, based on the state held before the transition:
  - CapIR: IR shift reg <= {0..0,01}.
  - ShIR: IR shift reg <= {tdi, sr[IR_WIDTH-1:1]}.
  - UpdIR: ir_out <= IR shift reg.
  - TLR: ir_out <= 1.
  - CapDR: selected DR shift reg loads per instruction:
    - IDCODE: IDCODE.
    - BYPASS: 0.
    - USER k: user_dr_in slice k.
  - ShDR: selected DR shifts right, tdi enters the MSB. Bypass is 1 bit.
  - UpdDR with USER k: user_dr_out slice k <= shift reg, and user_update[k]=1 for exactly one clk. Other instructions produce no pulse.
- Instruction decode:
  - 1 = IDCODE (32 bits).
  - 2..NUM_USER_DR+1 = USER 0..N-1.
  - All-ones and every other code = BYPASS.
- Actions on fall:
  - tdo <= LSB of the active shift register (IR in ShIR, selected DR in ShDR).
  - tdo_oe <= 1 iff the state is ShIR or ShDR; otherwise tdo_oe=0 and tdo holds its last value.
- TLR is reached from any state after 5 rises with tms=1.
- Simultaneous reset and tck edge: reset wins; the edge is discarded.

Optional Feature:
JTAG_TRST_EN:
- When defined, the block adds input trst_n (1 bit), synchronised via SYNC_STAGES flops.
- A synced trst_n=0 forces the TLR reset values on the next clk edge, exactly as rst_n does, except that user_dr_out retains its value.
- When not defined, the port is absent and only rst_n and the TMS sequence reset the TAP.

Test Plan:
- rst_n low 2 clk, then tck idle with tms=1 -> tap_state=4'hF, ir_out=4'h1, tdo_oe=0, user_dr_out=0.
- From TLR, tms sequence 0,1,0,0 then 32 ShDR clocks with tdi=0 -> tdo bits read LSB-first equal 32'h1000_0CE3, tdo_oe=1 only during the shift.
- Enter ShIR, shift out 4 bits while shifting in 4'hF -> tdo=1,0,0,0 (capture 0001); after UpdIR, ir_out=4'hF. DR path is then 1-bit BYPASS: tdi pattern 1,0,1,1 appears on tdo delayed by one tck.
- Load IR=4'h3 (USER1), user_dr_in slice1=8'hA5, shift 8 bits of 8'h3C -> tdo reads 8'hA5. At UpdDR, user_dr_out slice1=8'h3C, user_update=2'b10 for exactly 1 clk, and slice0 is unchanged.
- Assert rst_n mid-ShDR after 3 bits -> next clk tap_state=4'hF, ir_out=1, tdo_oe=0, no user_update pulse.
- tck toggled with 3-clk high/low times -> state advances once per rise and no rise is missed or duplicated over 100 tck cycles.

Source files
------------

// File: rtl/jtag_tap_sync.sv
// IEEE 1149.1 TAP controller with tck/tms/tdi oversampled into the clk domain.
// Optional JTAG_TRST_EN adds a synchronised trst_n that resets the TAP but keeps user_dr_out.
module jtag_tap_sync #(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE        = 32'h1000_0CE3,
  parameter int          NUM_USER_DR   = 2,
  parameter int          USER_DR_WIDTH = 8,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   tck,
  input  logic                                   tms,
  input  logic                                   tdi,
`ifdef JTAG_TRST_EN
  input  logic                                   trst_n,
`endif
  output logic                                   tdo,
  output logic                                   tdo_oe,
  output logic [3:0]                             tap_state,
  output logic [IR_WIDTH-1:0]                    ir_out,
  input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_in,
  output logic [NUM_USER_DR*USER_DR_WIDTH-1:0]   user_dr_out,
  output logic [NUM_USER_DR-1:0]                 user_update
);

  typedef enum logic [3:0] {
    S_EX2DR   = 4'h0,
    S_EX1DR   = 4'h1,
    S_SHDR    = 4'h2,
    S_PAUSEDR = 4'h3,
    S_SELIR   = 4'h4,
    S_UPDDR   = 4'h5,
    S_CAPDR   = 4'h6,
    S_SELDR   = 4'h7,
    S_EX2IR   = 4'h8,
    S_EX1IR   = 4'h9,
    S_SHIR    = 4'hA,
    S_PAUSEIR = 4'hB,
    S_RTI     = 4'hC,
    S_UPDIR   = 4'hD,
    S_CAPIR   = 4'hE,
    S_TLR     = 4'hF
  } tap_state_e;

  logic [SYNC_STAGES-1:0] tck_sync_reg;
  logic [SYNC_STAGES-1:0] tms_sync_reg;
  logic [SYNC_STAGES-1:0] tdi_sync_reg;
  logic                   tck_prev_reg;
  logic                   tck_s;
  logic                   tms_s;
  logic                   tdi_s;
  logic                   rise;
  logic                   fall;
  logic                   tap_rst;

  tap_state_e             state_reg;
  tap_state_e             state_next;

  logic [IR_WIDTH-1:0]    ir_sr_reg;
  logic [IR_WIDTH-1:0]    ir_out_reg;
  logic [31:0]            idcode_sr_reg;
  logic                   bypass_reg;
  logic                   tdo_reg;
  logic                   tdo_oe_reg;

  logic                   sel_idcode;
  logic                   sel_bypass;
  logic [NUM_USER_DR-1:0] user_sel;
  logic [NUM_USER_DR-1:0] user_lsb;
  logic                   dr_lsb;

  // Pin synchronisers; the oldest stage is the one the TAP acts on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tck_sync_reg <= '0;
      tms_sync_reg <= '0;
      tdi_sync_reg <= '0;
      tck_prev_reg <= 1'b0;
    end else begin
      tck_sync_reg <= {tck_sync_reg[SYNC_STAGES-2:0], tck};
      tms_sync_reg <= {tms_sync_reg[SYNC_STAGES-2:0], tms};
      tdi_sync_reg <= {tdi_sync_reg[SYNC_STAGES-2:0], tdi};
      tck_prev_reg <= tck_sync_reg[SYNC_STAGES-1];
    end
  end

  assign tck_s = tck_sync_reg[SYNC_STAGES-1];
  assign tms_s = tms_sync_reg[SYNC_STAGES-1];
  assign tdi_s = tdi_sync_reg[SYNC_STAGES-1];
  assign rise  = tck_s & ~tck_prev_reg;
  assign fall  = ~tck_s & tck_prev_reg;

`ifdef JTAG_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trst_sync_reg <= '0;
    end else begin
      trst_sync_reg <= {trst_sync_reg[SYNC_STAGES-2:0], trst_n};
    end
  end

  assign tap_rst = ~trst_sync_reg[SYNC_STAGES-1];
`else
  assign tap_rst = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || tap_rst) begin
      state_reg <= S_TLR;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (rise) begin
      case (state_reg)
        S_TLR:     state_next = tms_s ? S_TLR   : S_RTI;
        S_RTI:     state_next = tms_s ? S_SELDR : S_RTI;
        S_SELDR:   state_next = tms_s ? S_SELIR : S_CAPDR;
        S_CAPDR:   state_next = tms_s ? S_EX1DR : S_SHDR;
        S_SHDR:    state_next = tms_s ? S_EX1DR : S_SHDR;
        S_EX1DR:   state_next = tms_s ? S_UPDDR : S_PAUSEDR;
        S_PAUSEDR: state_next = tms_s ? S_EX2DR : S_PAUSEDR;
        S_EX2DR:   state_next = tms_s ? S_UPDDR : S_SHDR;
        S_UPDDR:   state_next = tms_s ? S_SELDR : S_RTI;
        S_SELIR:   state_next = tms_s ? S_TLR   : S_CAPIR;
        S_CAPIR:   state_next = tms_s ? S_EX1IR : S_SHIR;
        S_SHIR:    state_next = tms_s ? S_EX1IR : S_SHIR;
        S_EX1IR:   state_next = tms_s ? S_UPDIR : S_PAUSEIR;
        S_PAUSEIR: state_next = tms_s ? S_EX2IR : S_PAUSEIR;
        S_EX2IR:   state_next = tms_s ? S_UPDIR : S_SHIR;
        S_UPDIR:   state_next = tms_s ? S_SELDR : S_RTI;
        default:   state_next = S_TLR;
      endcase
    end
  end

  // Instruction decode: anything that is neither IDCODE nor a USER code is BYPASS.
  assign sel_idcode = (ir_out_reg == IR_WIDTH'(1));
  assign sel_bypass = ~sel_idcode & ~(|user_sel);

  always_comb begin
    dr_lsb = bypass_reg;
    if (sel_idcode) begin
      dr_lsb = idcode_sr_reg[0];
    end else if (|user_sel) begin
      dr_lsb = |(user_sel & user_lsb);
    end
  end

  // IR, IDCODE and BYPASS registers plus the tdo launch on the falling tck.
  always_ff @(posedge clk) begin
    if (!rst_n || tap_rst) begin
      ir_sr_reg     <= '0;
      ir_out_reg    <= IR_WIDTH'(1);
      idcode_sr_reg <= '0;
      bypass_reg    <= 1'b0;
      tdo_reg       <= 1'b0;
      tdo_oe_reg    <= 1'b0;
    end else begin
      if (rise) begin
        case (state_reg)
          S_TLR:   ir_out_reg <= IR_WIDTH'(1);
          S_CAPIR: ir_sr_reg  <= IR_WIDTH'(1);
          S_SHIR:  ir_sr_reg  <= {tdi_s, ir_sr_reg[IR_WIDTH-1:1]};
          S_UPDIR: ir_out_reg <= ir_sr_reg;
          S_CAPDR: begin
            if (sel_idcode) idcode_sr_reg <= IDCODE;
            if (sel_bypass) bypass_reg    <= 1'b0;
          end
          S_SHDR: begin
            if (sel_idcode) idcode_sr_reg <= {tdi_s, idcode_sr_reg[31:1]};
            if (sel_bypass) bypass_reg    <= tdi_s;
          end
          default: ;
        endcase
      end
      if (fall) begin
        if (state_reg == S_SHIR) begin
          tdo_reg    <= ir_sr_reg[0];
          tdo_oe_reg <= 1'b1;
        end else if (state_reg == S_SHDR) begin
          tdo_reg    <= dr_lsb;
          tdo_oe_reg <= 1'b1;
        end else begin
          tdo_oe_reg <= 1'b0;
        end
      end
    end
  end

  // One shift/update register pair per user DR; only the decoded one reacts.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_USER_DR; gi++) begin : g_user
      logic [USER_DR_WIDTH-1:0] sr_reg;
      logic [USER_DR_WIDTH-1:0] out_reg;
      logic                     upd_reg;
      logic [USER_DR_WIDTH:0]   shift_next;

      assign user_sel[gi] = (ir_out_reg == IR_WIDTH'(gi + 2));
      assign user_lsb[gi] = sr_reg[0];
      // Concatenate-then-drop keeps the shift legal for a 1-bit register.
      assign shift_next   = {tdi_s, sr_reg};

      always_ff @(posedge clk) begin
        if (!rst_n || tap_rst) begin
          sr_reg  <= '0;
          upd_reg <= 1'b0;
        end else begin
          upd_reg <= 1'b0;
          if (rise && user_sel[gi]) begin
            case (state_reg)
              S_CAPDR: sr_reg  <= user_dr_in[gi*USER_DR_WIDTH +: USER_DR_WIDTH];
              S_SHDR:  sr_reg  <= shift_next[USER_DR_WIDTH:1];
              S_UPDDR: upd_reg <= 1'b1;
              default: ;
            endcase
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_reg <= '0;
        end else if (!tap_rst && rise && user_sel[gi] && state_reg == S_UPDDR) begin
          out_reg <= sr_reg;
        end
      end

      assign user_dr_out[gi*USER_DR_WIDTH +: USER_DR_WIDTH] = out_reg;
      assign user_update[gi] = upd_reg;
    end
  endgenerate

  assign tap_state = state_reg;
  assign ir_out    = ir_out_reg;
  assign tdo       = tdo_reg;
  assign tdo_oe    = tdo_oe_reg;

endmodule
